// File: rtl/axi_read_intf_pkg.sv
// Shared definitions for the AXI read-side slave: burst/response encodings,
// internal target region codes, FSM state encoding and the burst error decode.
package axi_read_intf_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] REGION_FIFO = 2'b00;
    localparam logic [1:0] REGION_IRAM = 2'b01;
    localparam logic [1:0] REGION_WRAM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_SEND = 2'b11
    } rd_state_e;

    // A burst is answered with SLVERR on every beat (and never reaches a
    // target) when the beat is wider than the 4-byte bus, the burst type is
    // WRAP/reserved, or the region is unmapped.
    function automatic logic burst_is_err(input logic [2:0] size,
                                          input logic [1:0] burst,
                                          input logic [1:0] region);
        return (size > 3'd2) || burst[1] || (region == 2'b11);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address generator for AXI bursts.
// Ports: addr (current beat address), size (log2 bytes per beat),
//        burst (AXI burst type), next_addr (address of the following beat).
// INCR advances by 1<<size modulo 2^ADDR_WIDTH (no 4KB check); FIXED and
// anything else hold the address.
module axi_burst_addr_gen
    import axi_read_intf_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;

    assign step      = ADDR_WIDTH'(1) << size;
    assign next_addr = (burst == AXI_BURST_INCR) ? addr + step : addr;

endmodule

// File: rtl/axi_read_intf.sv
// AXI4 read-channel slave (AR/R). Accepts one burst at a time and turns each
// beat into a single-beat internal read to FIFO/IRAM/WRAM, returning the data
// on R. Error bursts are answered locally with SLVERR beats.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   AR*                             AXI read address channel (slave side)
//   R*                              AXI read data channel (slave side)
//   axi_rd_vld/addr/region          one-cycle internal read request
//   {fifo,iram,wram}_rd_done/rdata  target completion and data
//   fifo_err                        FIFO read error, qualified by fifo_rd_done
module axi_read_intf
    import axi_read_intf_pkg::*;
#(
    parameter int ARID_WIDTH   = 8,
    parameter int ARADDR_WIDTH = 11,
    parameter int RDATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ARID_WIDTH-1:0]   ARID,
    input  logic [ARADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [3:0]              ARREGION,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ARID_WIDTH-1:0]   RID,
    output logic [RDATA_WIDTH-1:0]  RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    axi_rd_vld,
    output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
    output logic [1:0]              axi_rd_region,
    input  logic                    fifo_rd_done,
    input  logic                    iram_rd_done,
    input  logic                    wram_rd_done,
    input  logic [RDATA_WIDTH-1:0]  fifo_rdata,
    input  logic [RDATA_WIDTH-1:0]  iram_rdata,
    input  logic [RDATA_WIDTH-1:0]  wram_rdata,
    input  logic                    fifo_err
);

    rd_state_e              state;
    logic [7:0]             beat_cnt;   // beats remaining after the current one
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic                   err_q;
    logic [ARADDR_WIDTH-1:0] next_addr;
    logic                   tgt_done;
    logic [RDATA_WIDTH-1:0] tgt_data;
    logic                   unused_region_hi;

    // Only the low two region bits select a target.
    assign unused_region_hi = ^ARREGION[3:2];

    // axi_rd_addr doubles as the burst's current-beat address register.
    axi_burst_addr_gen #(.ADDR_WIDTH(ARADDR_WIDTH)) u_addr_gen (
        .addr      (axi_rd_addr),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Only the latched target's completion counts.
    always_comb begin
        tgt_done = 1'b0;
        tgt_data = '0;
        case (axi_rd_region)
            REGION_FIFO: begin tgt_done = fifo_rd_done; tgt_data = fifo_rdata; end
            REGION_IRAM: begin tgt_done = iram_rd_done; tgt_data = iram_rdata; end
            REGION_WRAM: begin tgt_done = wram_rd_done; tgt_data = wram_rdata; end
            default:     begin tgt_done = 1'b0;         tgt_data = '0;         end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ARREADY       <= 1'b1;
            RID           <= '0;
            RDATA         <= '0;
            RRESP         <= AXI_RESP_OKAY;
            RLAST         <= 1'b0;
            RVALID        <= 1'b0;
            axi_rd_vld    <= 1'b0;
            axi_rd_addr   <= '0;
            axi_rd_region <= '0;
            beat_cnt      <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ARVALID) begin
                        RID           <= ARID;
                        axi_rd_addr   <= ARADDR;
                        axi_rd_region <= ARREGION[1:0];
                        beat_cnt      <= ARLEN;
                        size_q        <= ARSIZE;
                        burst_q       <= ARBURST;
                        ARREADY       <= 1'b0;
                        if (burst_is_err(ARSIZE, ARBURST, ARREGION[1:0])) begin
                            // Error bursts skip the targets entirely.
                            err_q  <= 1'b1;
                            state  <= ST_SEND;
                            RVALID <= 1'b1;
                            RDATA  <= '0;
                            RRESP  <= AXI_RESP_SLVERR;
                            RLAST  <= (ARLEN == 8'd0);
                        end else begin
                            err_q      <= 1'b0;
                            state      <= ST_REQ;
                            axi_rd_vld <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    axi_rd_vld <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tgt_done) begin
                        RDATA  <= tgt_data;
                        RRESP  <= (axi_rd_region == REGION_FIFO && fifo_err)
                                  ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        RLAST  <= (beat_cnt == 8'd0);
                        RVALID <= 1'b1;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            beat_cnt    <= beat_cnt - 8'd1;
                            axi_rd_addr <= next_addr;
                            if (err_q) begin
                                // Back-to-back SLVERR beats, RVALID stays high.
                                RLAST <= (beat_cnt == 8'd1);
                            end else begin
                                RVALID     <= 1'b0;
                                axi_rd_vld <= 1'b1;
                                state      <= ST_REQ;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_intf.sv
module tb_axi_read_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ARID = '0;
    logic [10:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic [3:0]  ARREGION = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID;
    logic        RREADY = 1'b1;
    logic        axi_rd_vld;
    logic [10:0] axi_rd_addr;
    logic [1:0]  axi_rd_region;
    logic        fifo_rd_done = 1'b0, iram_rd_done = 1'b0, wram_done_r = 1'b0, spur_wram = 1'b0;
    logic        wram_rd_done;
    logic [31:0] fifo_rdata = 32'hDEAD_BEEF, iram_rdata = 32'hDEAD_BEEF, wram_rdata = 32'hDEAD_BEEF;
    logic        fifo_err = 1'b0;

    assign wram_rd_done = wram_done_r | spur_wram;

    axi_read_intf dut (
        .clk(clk), .rst_n(rst_n),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .axi_rd_vld(axi_rd_vld), .axi_rd_addr(axi_rd_addr), .axi_rd_region(axi_rd_region),
        .fifo_rd_done(fifo_rd_done), .iram_rd_done(iram_rd_done), .wram_rd_done(wram_rd_done),
        .fifo_rdata(fifo_rdata), .iram_rdata(iram_rdata), .wram_rdata(wram_rdata),
        .fifo_err(fifo_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
    typedef struct { logic [10:0] addr; logic [1:0] region; } q_t;
    typedef struct { logic [31:0] data; logic err; logic [1:0] region; } rsp_t;

    r_t   exp_r[$];
    q_t   exp_req[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   resp_k = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [10:0] a, input logic [1:0] r);
        return 32'hD000_0000 | (32'(r) << 16) | 32'(a);
    endfunction

    // Target model: answers each request after resp_k cycles on the expected region.
    initial begin
        rsp_t s;
        forever begin
            @(negedge clk);
            if (rst_n && axi_rd_vld && rsp_q.size() > 0) begin
                s = rsp_q.pop_front();
                @(posedge clk); #1;
                repeat (resp_k - 1) begin @(posedge clk); #1; end
                case (s.region)
                    2'b00: begin fifo_rd_done = 1'b1; fifo_rdata = s.data; fifo_err = s.err; end
                    2'b01: begin iram_rd_done = 1'b1; iram_rdata = s.data; end
                    default: begin wram_done_r = 1'b1; wram_rdata = s.data; end
                endcase
                @(posedge clk); #1;
                fifo_rd_done = 1'b0; iram_rd_done = 1'b0; wram_done_r = 1'b0; fifo_err = 1'b0;
                fifo_rdata = 32'hDEAD_BEEF; iram_rdata = 32'hDEAD_BEEF; wram_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: compares requests and R beats against the scoreboard queues.
    initial begin
        q_t q; r_t r;
        logic held, last_seen;
        logic [34:0] prev;
        held = 1'b0; last_seen = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0; last_seen = 1'b0;
            end else begin
                if (axi_rd_vld) begin
                    if (exp_req.size() == 0) chk("unexpected_req", 64'(axi_rd_addr), 64'h1_0000);
                    else begin
                        q = exp_req.pop_front();
                        chk("req_addr_region", 64'({axi_rd_addr, axi_rd_region}), 64'({q.addr, q.region}));
                    end
                end
                if (last_seen) chk("arready_after_last", 64'(ARREADY), 64'd1);
                last_seen = 1'b0;
                if (RVALID) begin
                    chk("arready_busy", 64'(ARREADY), 64'd0);
                    if (held) chk("r_stable", 64'({RDATA, RRESP, RLAST}), 64'(prev));
                    if (RREADY) begin
                        held = 1'b0;
                        if (exp_r.size() == 0) chk("unexpected_beat", 64'(RDATA), 64'h1_0000_0000);
                        else begin
                            r = exp_r.pop_front();
                            chk("r_beat", 64'({RID, RDATA, RRESP, RLAST}), 64'({r.id, r.data, r.resp, r.last}));
                            if (RLAST) last_seen = 1'b1;
                        end
                    end else begin
                        held = 1'b1;
                        prev = {RDATA, RRESP, RLAST};
                    end
                end else held = 1'b0;
            end
        end
    end

    task automatic issue(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] region,
                         input logic [15:0] emask);
        logic [10:0] a; logic err; r_t r; q_t q; rsp_t s; int w;
        a = addr;
        err = (size > 3'd2) || burst[1] || (region[1:0] == 2'b11);
        for (int i = 0; i <= int'(len); i++) begin
            r.id = id; r.last = (i == int'(len));
            if (err) begin
                r.data = '0; r.resp = 2'b10;
            end else begin
                q.addr = a; q.region = region[1:0]; exp_req.push_back(q);
                s.data = mdata(a, region[1:0]); s.err = emask[i[3:0]]; s.region = region[1:0];
                rsp_q.push_back(s);
                r.data = s.data;
                r.resp = (region[1:0] == 2'b00 && emask[i[3:0]]) ? 2'b10 : 2'b00;
                if (burst == 2'b01) a = a + (11'd1 << size);
            end
            exp_r.push_back(r);
        end
        w = 0;
        while (!ARREADY && w < 100) begin @(posedge clk); #1; w++; end
        if (!ARREADY) chk("arready_timeout", 64'(ARREADY), 64'd1);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARREGION = region;
        ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_r.size() > 0 || exp_req.size() > 0) && w < 400) begin @(negedge clk); w++; end
        chk("drain_left", 64'(exp_r.size() + exp_req.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arready"}, 64'(ARREADY), 64'd1);
        chk({tag, "_valids"}, 64'({RVALID, RLAST, axi_rd_vld}), 64'd0);
        chk({tag, "_data"}, 64'({RDATA, RID, RRESP, axi_rd_addr, axi_rd_region}), 64'd0);
    endtask

    initial begin
        int w;
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // INCR IRAM, addresses 0x010/0x014/0x018/0x01C
        resp_k = 1;
        issue(8'h5A, 11'h010, 8'd3, 3'd2, 2'b01, 4'b0001, 16'h0);
        drain();

        // FIXED FIFO, error on beat 1 only
        resp_k = 2;
        issue(8'hA3, 11'h123, 8'd2, 3'd1, 2'b00, 4'b0000, 16'h0002);
        drain();

        // Unmapped region: two local SLVERR beats, no requests
        issue(8'h33, 11'h050, 8'd1, 3'd2, 2'b01, 4'b0011, 16'h0);
        drain();
        // WRAP and oversize bursts are errors too
        issue(8'h44, 11'h060, 8'd2, 3'd2, 2'b10, 4'b0001, 16'h0);
        drain();
        issue(8'h45, 11'h070, 8'd0, 3'd3, 2'b01, 4'b0010, 16'h0);
        drain();

        // RREADY stall with spurious WRAM done pulses
        resp_k = 1;
        RREADY = 1'b0;
        issue(8'h77, 11'h200, 8'd1, 3'd0, 2'b01, 4'b0010, 16'h0);
        w = 0;
        while (!RVALID && w < 50) begin @(posedge clk); #1; w++; end
        chk("stall_rvalid", 64'(RVALID), 64'd1);
        for (int i = 0; i < 5; i++) begin
            spur_wram = (i % 2 == 0);
            @(negedge clk);
            chk("stall_no_req", 64'(axi_rd_vld), 64'd0);
            @(posedge clk); #1;
        end
        spur_wram = 1'b0;
        RREADY = 1'b1;
        drain();

        // Address wrap 0x7FC -> 0x000, ARVALID while busy ignored
        issue(8'h19, 11'h7FC, 8'd1, 3'd2, 2'b01, 4'b0001, 16'h0);
        ARADDR = 11'h3AA; ARID = 8'hEE; ARLEN = 8'd0; ARVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_arready", 64'(ARREADY), 64'd0);
        end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        drain();

        // Reset while waiting on the target
        resp_k = 6;
        issue(8'h21, 11'h040, 8'd2, 3'd2, 2'b01, 4'b0001, 16'h0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        exp_r.delete(); exp_req.delete(); rsp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("post_rst_idle", 64'({ARREADY, RVALID}), 64'b10);
        resp_k = 1;
        issue(8'h62, 11'h100, 8'd1, 3'd1, 2'b01, 4'b0010, 16'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
